lcd_bus_arbiter: RTL
====================

// Module: lcd_bus_arbiter
// PURPOSE
//  Shares the 8-bit 8080-style LCD write bus (lcd_data/lcd_rs/lcd_wr) between two requesters.
//  - Command port: init sequencer / register writes.
//  - Pixel port: frame streamer.
//  Generates WR strobe timing, locks grants for whole bursts and, optionally, aligns frames to lcd_fmark.
//  Sits between the LCD sequencers and the LCD pins in chip.
// PARAMETERS
//  WR_LOW   2  clk cycles lcd_wr held low per byte (>=1)
//  WR_HIGH  2  clk cycles lcd_wr held high per byte, data still held (>=1)
// PORTS
//  clk          in   1  system clock; all logic on posedge
//  rst          in   1  synchronous, active-high reset
//  cmd_valid    in   1  command byte available
//  cmd_ready    out  1  command byte accepted this cycle (valid&ready)
//  cmd_data     in   8  command/parameter byte
//  cmd_rs       in   1  rs level for this byte (0=command, 1=parameter)
//  cmd_last     in   1  last byte of command burst; releases grant
//  pix_valid    in   1  pixel byte available
//  pix_ready    out  1  pixel byte accepted this cycle
//  pix_data     in   8  pixel byte (always sent with rs=1)
//  pix_last     in   1  last byte of frame; releases grant
//  lcd_fmark    in   1  tearing-effect input from panel (async)
//  lcd_data     out  8  LCD bus data
//  lcd_rs       out  1  LCD register select
//  lcd_wr       out  1  LCD write strobe, active low
//  lcd_cs_act   out  1  1 while any grant held (drives CS pad enable)
//  frame_done   out  1  one-cycle pulse after final WR_HIGH of pix_last byte
// BEHAVIOUR
//  - Reset: lcd_wr=1, lcd_data=0, lcd_rs=0, lcd_cs_act=0, cmd_ready=pix_ready=0, frame_done=0, owner=NONE, FSM=IDLE.
//  - FSM states: IDLE, ARM (fmark wait, optional), ACCEPT, WR_LO, WR_HI.
//  - IDLE with owner=NONE: cmd_valid wins over pix_valid. A simultaneous request grants CMD.
//    - Grant CMD -> ACCEPT.
//    - Grant PIX -> ARM (macro on) or ACCEPT (macro off).
//    - lcd_cs_act rises the cycle the grant is taken.
//  - Grant is sticky until the *_last byte completes WR_HI. No preemption: a cmd request during a frame waits until frame end.
//  - ACCEPT: ready of the owner asserted combinationally while in ACCEPT; other ready stays 0.
//    - On valid&ready: latch data/rs/last onto lcd_data/lcd_rs, go WR_LO next cycle.
//    - Owner valid=0: stay in ACCEPT with grant held; lcd_wr stays 1.
//  - WR_LO: lcd_wr=0 for exactly WR_LOW cycles. WR_HI: lcd_wr=1 for exactly WR_HIGH cycles, data/rs stable.
//  - End of WR_HI: if latched last, go IDLE and owner=NONE; lcd_cs_act falls the next cycle; frame_done pulses if owner was PIX. Else go ACCEPT.
//  - Throughput: 1 byte per WR_LOW+WR_HIGH+1 cycles. Latency valid->lcd_wr fall: 2 cycles (from ACCEPT).
//  - Down-counter for phase timing: width $clog2(max(WR_LOW,WR_HIGH)+1); no wrap; reloaded each phase.
//  - Reset mid-transfer: returns to reset values on the next edge. A partial byte is abandoned and the grant dropped.
//  - valid/data changes while not ready are ignored. last on a non-accepted cycle is ignored.
// CONFIGURATION
//  LCD_ARB_FMARK_SYNC_EN defined:
//    - lcd_fmark double-flop synchronised; rising edge detected.
//    - PIX grant enters ARM; stays until synced rising edge, then ACCEPT.
//    - pix_ready=0 in ARM. Cmd requests cannot enter while PIX is armed.
//  Not defined: no synchroniser, no ARM state; PIX grant goes straight to ACCEPT; lcd_fmark unused.
// STRUCTURE
//  Shared package lcd_pkg: state encoding localparams, OWNER_NONE/CMD/PIX, default WR_LOW/WR_HIGH.
//  One sub-module: lcd_wr_timer (load, count, done) for the WR_LO/WR_HI phase counter.
//  Grant/FSM/data register stay in lcd_bus_arbiter.
// TESTING (WR_LOW=2, WR_HIGH=2)
//  - Reset: hold rst 3 cycles mid-byte -> lcd_wr=1, lcd_cs_act=0, readies 0; next accept restarts cleanly.
//  - Single cmd 0x2C, rs=0, last=1 -> lcd_data=0x2C, rs=0, lcd_wr low exactly 2 cycles, high 2, cs_act drops after.
//  - cmd and pix valid same cycle -> CMD granted first. 3-byte cmd burst {0x2A,0x00,0xEF} completes before pix_ready rises.
//  - Pixel frame of 4 bytes {0xF8,0x00,0x07,0xE0}, cmd_valid raised after byte 2 -> no cmd byte until frame_done pulse.
//  - Owner stalls (pix_valid=0 for 5 cycles mid-frame) -> lcd_wr stays 1, lcd_cs_act stays 1, resumes with next byte.
//  - Macro on: pix_valid at cycle 10, fmark rises at cycle 40 -> first lcd_wr fall at cycle 40+2 sync+1+2; macro off -> fall at cycle 12.

Source files
------------

// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
//   Shared constants for the LCD write-bus arbiter:
//   - FSM state encoding (IDLE, ARM, ACCEPT, WR_LO, WR_HI)
//   - bus owner encoding (NONE, CMD, PIX)
//   - default WR strobe phase lengths
//   - helper that sizes the phase down-counter
// ---------------------------------------------------------------------------
package lcd_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARM    = 3'd1;
    localparam logic [2:0] ST_ACCEPT = 3'd2;
    localparam logic [2:0] ST_WR_LO  = 3'd3;
    localparam logic [2:0] ST_WR_HI  = 3'd4;

    localparam logic [1:0] OWNER_NONE = 2'd0;
    localparam logic [1:0] OWNER_CMD  = 2'd1;
    localparam logic [1:0] OWNER_PIX  = 2'd2;

    localparam int WR_LOW_DEF  = 2;
    localparam int WR_HIGH_DEF = 2;

    // Counter must hold the larger of the two phase lengths.
    function automatic int phase_cnt_width(input int lo, input int hi);
        int m;
        m = (lo > hi) ? lo : hi;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/lcd_wr_timer.sv
// ---------------------------------------------------------------------------
// lcd_wr_timer
//   Down-counter that times one WR strobe phase. Loading N makes done_o
//   assert N cycles later, so a phase of length L is loaded with L-1 and
//   lasts exactly L cycles. The counter saturates at zero (no wrap).
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   load_i       load load_val_i this cycle (start of a phase)
//   load_val_i   phase length minus one
//   count_en_i   decrement while a phase is running
//   done_o       counter is at zero: last cycle of the current phase
// ---------------------------------------------------------------------------
module lcd_wr_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             count_en_i,
    output logic             done_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_en_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/lcd_bus_arbiter.sv
// ---------------------------------------------------------------------------
// lcd_bus_arbiter
//   Shares the 8-bit 8080-style LCD write bus between a command requester
//   (init sequencer / register writes) and a pixel requester (frame
//   streamer). Generates the WR strobe, holds the grant for a whole burst
//   (released by the *_last byte) and, optionally, starts each pixel frame
//   on a rising edge of the panel tearing-effect signal.
//
// Configuration macro
//   LCD_ARB_FMARK_SYNC_EN  defined: lcd_fmark is double-flop synchronised,
//                          a pixel grant waits in ARM for its rising edge.
//                          undefined: no ARM state, lcd_fmark ignored.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   cmd_valid/ready/data/rs/last   command byte stream
//   pix_valid/ready/data/last      pixel byte stream (always rs=1)
//   lcd_fmark                      tearing-effect input (asynchronous)
//   lcd_data/lcd_rs/lcd_wr         LCD bus pins (lcd_wr active low)
//   lcd_cs_act                     high while any grant is held
//   frame_done                     one-cycle pulse after the last pixel byte
// ---------------------------------------------------------------------------
module lcd_bus_arbiter
    import lcd_pkg::*;
#(
    parameter int WR_LOW  = WR_LOW_DEF,
    parameter int WR_HIGH = WR_HIGH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    input  logic       cmd_rs,
    input  logic       cmd_last,
    input  logic       pix_valid,
    output logic       pix_ready,
    input  logic [7:0] pix_data,
    input  logic       pix_last,
    input  logic       lcd_fmark,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_wr,
    output logic       lcd_cs_act,
    output logic       frame_done
);

    localparam int CNT_W = phase_cnt_width(WR_LOW, WR_HIGH);
    localparam logic [CNT_W-1:0] LO_LOAD = CNT_W'(WR_LOW - 1);
    localparam logic [CNT_W-1:0] HI_LOAD = CNT_W'(WR_HIGH - 1);

    logic [2:0] state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [7:0] data_q,  data_d;
    logic       rs_q,    rs_d;
    logic       last_q,  last_d;
    logic       wr_q,    wr_d;
    logic       frame_done_q, frame_done_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_done;
    logic             accept;

`ifdef LCD_ARB_FMARK_SYNC_EN
    // Two flops for metastability, a third for edge history; the edge
    // pulse itself is registered so ARM leaves on a clean flop output.
    logic fmark_s1_q, fmark_s2_q, fmark_s3_q, fmark_rise_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fmark_s1_q   <= 1'b0;
            fmark_s2_q   <= 1'b0;
            fmark_s3_q   <= 1'b0;
            fmark_rise_q <= 1'b0;
        end else begin
            fmark_s1_q   <= lcd_fmark;
            fmark_s2_q   <= fmark_s1_q;
            fmark_s3_q   <= fmark_s2_q;
            fmark_rise_q <= fmark_s2_q & ~fmark_s3_q;
        end
    end
`else
    logic unused_fmark;
    assign unused_fmark = lcd_fmark;
`endif

    // Ready is a pure decode of registered state: only the owner sees it,
    // and only while waiting for its next byte.
    assign cmd_ready = (state_q == ST_ACCEPT) && (owner_q == OWNER_CMD);
    assign pix_ready = (state_q == ST_ACCEPT) && (owner_q == OWNER_PIX);
    assign accept    = (cmd_ready && cmd_valid) || (pix_ready && pix_valid);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        data_d       = data_q;
        rs_d         = rs_q;
        last_d       = last_q;
        wr_d         = wr_q;
        frame_done_d = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;

        case (state_q)
            ST_IDLE: begin
                // Command wins a tie; pixels wait for the next free slot.
                if (cmd_valid) begin
                    owner_d = OWNER_CMD;
                    state_d = ST_ACCEPT;
                end else if (pix_valid) begin
                    owner_d = OWNER_PIX;
`ifdef LCD_ARB_FMARK_SYNC_EN
                    state_d = ST_ARM;
`else
                    state_d = ST_ACCEPT;
`endif
                end
            end
`ifdef LCD_ARB_FMARK_SYNC_EN
            ST_ARM: begin
                if (fmark_rise_q) begin
                    state_d = ST_ACCEPT;
                end
            end
`endif
            ST_ACCEPT: begin
                if (accept) begin
                    if (owner_q == OWNER_CMD) begin
                        data_d = cmd_data;
                        rs_d   = cmd_rs;
                        last_d = cmd_last;
                    end else begin
                        data_d = pix_data;
                        rs_d   = 1'b1;
                        last_d = pix_last;
                    end
                    wr_d         = 1'b0;
                    state_d      = ST_WR_LO;
                    tmr_load     = 1'b1;
                    tmr_load_val = LO_LOAD;
                end
            end
            ST_WR_LO: begin
                if (tmr_done) begin
                    wr_d         = 1'b1;
                    state_d      = ST_WR_HI;
                    tmr_load     = 1'b1;
                    tmr_load_val = HI_LOAD;
                end
            end
            ST_WR_HI: begin
                if (tmr_done) begin
                    if (last_q) begin
                        state_d      = ST_IDLE;
                        owner_d      = OWNER_NONE;
                        frame_done_d = (owner_q == OWNER_PIX);
                    end else begin
                        state_d = ST_ACCEPT;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWNER_NONE;
                wr_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWNER_NONE;
            data_q       <= 8'h00;
            rs_q         <= 1'b0;
            last_q       <= 1'b0;
            wr_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            data_q       <= data_d;
            rs_q         <= rs_d;
            last_q       <= last_d;
            wr_q         <= wr_d;
            frame_done_q <= frame_done_d;
        end
    end

    lcd_wr_timer #(
        .WIDTH (CNT_W)
    ) u_wr_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .count_en_i ((state_q == ST_WR_LO) || (state_q == ST_WR_HI)),
        .done_o     (tmr_done)
    );

    assign lcd_data   = data_q;
    assign lcd_rs     = rs_q;
    assign lcd_wr     = wr_q;
    assign lcd_cs_act = (owner_q != OWNER_NONE);
    assign frame_done = frame_done_q;

endmodule
